seq_detect_ctrl: RTL and testbench

- Programmable serial pattern-detection controller that frames and counts occurrences of a 1..MAX_LEN-bit pattern on a handshaked serial bit stream.
- Generalises the fixed "011" detectors: the pattern, its length, overlap policy, Mealy/Moore output timing and a match-count target are all runtime-configurable.
- Sits between a serial bit source (valid/ready) and a host that configures it, arms it and collects a done flag.

---
 rtl/seq_detect_ctrl.sv | 142 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with match counting
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               cfg_overlap,
    input  logic               cfg_mealy,
    input  logic               start,
    input  logic               abort,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               bit_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int HCW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [3:0]         len_q;
    logic [CNT_W-1:0]   target_q;
    logic               overlap_q;
    logic               mealy_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [HCW-1:0]     hist_cnt_q;
    logic [CNT_W-1:0]   count_q;
    logic               match_q;
    logic               err_q;

    logic               in_scan;
    logic               xfer;
    logic               hit;
    logic               start_ok;
    logic [3:0]         eff_len;
    logic [CNT_W-1:0]   eff_target;
    logic [MAX_LEN-1:0] hist_d;
    logic [HCW-1:0]     hist_cnt_d;
    logic [CNT_W-1:0]   count_d;
    logic [MAX_LEN-1:0] len_mask;

    assign in_scan = (state_q == S_SCAN);
    assign xfer    = in_scan && !abort && bit_valid;

    // A start in the same cycle as a config write is judged on the new values.
    assign eff_len    = (!in_scan && cfg_we) ? cfg_len    : len_q;
    assign eff_target = (!in_scan && cfg_we) ? cfg_target : target_q;
    assign start_ok   = (eff_len != 4'd0) && ({28'd0, eff_len} <= 32'(MAX_LEN))
                        && (eff_target != '0);

    assign hist_d     = {hist_q[MAX_LEN-2:0], bit_in};
    assign hist_cnt_d = (hist_cnt_q == HCW'(MAX_LEN)) ? hist_cnt_q : hist_cnt_q + HCW'(1);
    assign count_d    = count_q + CNT_W'(1);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign hit = xfer && (((hist_d ^ pat_q) & len_mask) == '0)
                 && (int'(hist_cnt_d) >= int'(len_q));

    assign bit_ready   = in_scan && !abort;
    assign busy        = in_scan;
    assign done        = (state_q == S_DONE);
    assign match       = mealy_q ? hit : match_q;
    assign match_count = count_q;
    assign err         = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pat_q      <= MAX_LEN'(3);
            len_q      <= 4'd3;
            target_q   <= CNT_W'(1);
            overlap_q  <= 1'b1;
            mealy_q    <= 1'b0;
            hist_q     <= '0;
            hist_cnt_q <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            match_q <= hit && !mealy_q;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cfg_we) begin
                        pat_q     <= cfg_pattern;
                        len_q     <= cfg_len;
                        target_q  <= cfg_target;
                        overlap_q <= cfg_overlap;
                        mealy_q   <= cfg_mealy;
                    end
                    if (start) begin
                        if (start_ok) begin
                            err_q      <= 1'b0;
                            count_q    <= '0;
                            hist_q     <= '0;
                            hist_cnt_q <= '0;
                            state_q    <= S_SCAN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (xfer) begin
                        hist_q     <= hist_d;
                        hist_cnt_q <= (hit && !overlap_q) ? '0 : hist_cnt_d;
                        if (hit) begin
                            count_q <= count_d;
                            if (count_d == target_q) begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - randomized and directed bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic       cfg_overlap;
    logic       cfg_mealy;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       bit_in;
    logic       bit_ready;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 scanning, 2 done; history kept as a queue of received bits.
    int         m_state;
    bit         m_err;
    int         m_count;
    bit         m_pend;
    bit         m_hist[$];
    logic [7:0] m_pat;
    int         m_len;
    int         m_target;
    bit         m_overlap;
    bit         m_mealy;

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_overlap(cfg_overlap),
        .cfg_mealy(cfg_mealy), .start(start), .abort(abort), .bit_valid(bit_valid),
        .bit_in(bit_in), .bit_ready(bit_ready), .match(match), .match_count(match_count),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_err = 0; m_count = 0; m_pend = 0; m_hist.delete();
        m_pat = 8'b0000_0011; m_len = 3; m_target = 1; m_overlap = 1; m_mealy = 0;
    endtask

    task automatic step();
        bit exp_ready, xfer, hit;
        bit tmp[$];
        @(negedge clk);
        exp_ready = (m_state == 1) && !abort;
        xfer      = exp_ready && bit_valid;
        hit       = 0;
        tmp       = m_hist;
        if (xfer) begin
            tmp.push_back(bit_in);
            if (tmp.size() >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (tmp[tmp.size()-1-i] != m_pat[i]) hit = 0;
            end
        end
        check_val("bit_ready", bit_ready, exp_ready);
        check_val("match", match, m_mealy ? hit : m_pend);
        check_val("match_count", match_count, m_count);
        check_val("busy", busy, m_state == 1);
        check_val("done", done, m_state == 2);
        check_val("err", err, m_err);
        m_pend = hit && !m_mealy;
        if (m_state == 1) begin
            if (abort) m_state = 0;
            else if (xfer) begin
                while (tmp.size() > 8) void'(tmp.pop_front());
                m_hist = tmp;
                if (hit) begin
                    m_count++;
                    if (!m_overlap) m_hist.delete();
                    if (m_count == m_target) m_state = 2;
                end
            end
        end else begin
            if (cfg_we) begin
                m_pat = cfg_pattern; m_len = cfg_len; m_target = cfg_target;
                m_overlap = cfg_overlap; m_mealy = cfg_mealy;
            end
            if (start) begin
                if (m_len == 0 || m_len > 8 || m_target == 0) m_err = 1;
                else begin
                    m_err = 0; m_count = 0; m_hist.delete(); m_state = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input bit st, input bit ab, input bit v, input bit b);
        cfg_we = we; start = st; abort = ab; bit_valid = v; bit_in = b;
        step();
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t,
                           input bit ov, input bit me);
        cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_overlap = ov; cfg_mealy = me;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) drive(0, 0, 0, 1, v[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        cfg_we = 0; start = 0; abort = 0; bit_valid = 0; bit_in = 0;
        set_cfg(8'h00, 4'd0, 8'd0, 0, 0);
        model_reset();
        #12;
        check_val("rst_ready", bit_ready, 0);
        check_val("rst_count", match_count, 0);
        check_val("rst_busy_done_err_match", {busy, done, err, match}, 4'b0000);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Defaults "011", Moore
        drive(0, 1, 0, 0, 0);
        send_bits(16'b011, 3);
        idle(2);

        // Mealy timing
        set_cfg(8'b011, 4'd3, 8'd1, 1, 1);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        send_bits(16'b011, 3);
        idle(2);

        // Overlap on, then off
        set_cfg(8'b1010, 4'd4, 8'd8, 1, 0);
        drive(1, 1, 0, 0, 0);
        send_bits(16'b1010101, 7);
        idle(1);
        drive(0, 0, 1, 1, 1);
        set_cfg(8'b1010, 4'd4, 8'd8, 0, 0);
        drive(1, 1, 0, 0, 0);
        send_bits(16'b1010101, 7);
        idle(1);
        check_val("nonoverlap_count", match_count, 1);
        check_val("nonoverlap_busy", busy, 1);

        // Target stop; the fourth bit must be refused
        drive(0, 0, 1, 0, 0);
        set_cfg(8'b11, 4'd2, 8'd2, 1, 0);
        drive(1, 1, 0, 0, 0);
        send_bits(16'b1111, 4);
        check_val("target_count", match_count, 2);
        idle(1);

        // Abort collision with a valid bit
        set_cfg(8'b0110, 4'd4, 8'd5, 1, 1);
        drive(1, 1, 0, 0, 0);
        send_bits(16'b0110110, 7);
        drive(0, 0, 1, 1, 0);
        idle(2);

        // Illegal configs, then legal config written together with start
        set_cfg(8'b1, 4'd0, 8'd1, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        idle(1);
        set_cfg(8'b1, 4'd9, 8'd1, 1, 0);
        drive(1, 1, 0, 0, 0);
        set_cfg(8'b1, 4'd1, 8'd0, 1, 0);
        drive(1, 1, 0, 0, 0);
        set_cfg(8'b101, 4'd3, 8'd2, 0, 1);
        drive(1, 1, 0, 0, 0);
        send_bits(16'b101101, 6);
        idle(2);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(1, 4));
                cfg_target  = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
                cfg_overlap = 1'($urandom);
                cfg_mealy   = 1'($urandom);
                cfg_we      = 1;
            end else cfg_we = 0;
            start     = ($urandom_range(0, 7) == 0);
            abort     = ($urandom_range(0, 29) == 0);
            bit_valid = ($urandom_range(0, 3) != 0);
            bit_in    = 1'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a scan
        set_cfg(8'b11, 4'd2, 8'd9, 1, 1);
        drive(1, 1, 0, 0, 0);
        send_bits(16'b111, 3);
        cfg_we = 0; start = 0; abort = 0; bit_valid = 1; bit_in = 1;
        #2 rst = 1'b0;
        #1;
        check_val("async_ready", bit_ready, 0);
        check_val("async_match", match, 0);
        check_val("async_count", match_count, 0);
        check_val("async_busy_done_err", {busy, done, err}, 3'b000);
        model_reset();
        bit_valid = 0; bit_in = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0);
        send_bits(16'b011, 3);
        idle(1);
        check_val("default_restored_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
